// File: rtl/mux_n_1_scan_if.sv
// Bus bundle for the registered N:1 scan multiplexer: selection controls,
// packed channel inputs and the one-entry output handshake.
interface mux_n_1_scan_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      MODE;
  logic [SEL_W-1:0]          SEL;
  logic [CHANNELS-1:0]       EN;
  logic [CHANNELS*WIDTH-1:0] D_IN;
  logic [WIDTH-1:0]          Z;
  logic [SEL_W-1:0]          CH;
  logic                      Z_VALID;
  logic                      Z_READY;

  // Source/consumer side: drives selection, data and ready; observes the output word.
  modport master (
    output MODE, SEL, EN, D_IN, Z_READY,
    input  Z, CH, Z_VALID
  );

  // Multiplexer side.
  modport slave (
    input  MODE, SEL, EN, D_IN, Z_READY,
    output Z, CH, Z_VALID
  );
endinterface

// File: rtl/mux_n_1_scan.sv
// Registered N:1 word multiplexer. A word is chosen either by an explicit
// channel index or by a round-robin scan over an enable mask, and is held in
// a one-entry output register with a valid/ready handshake. All outputs are
// flops; the inputs only steer the next-state logic.
module mux_n_1_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_n_1_scan_if.slave  bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             cand_found;
  logic [SEL_W-1:0] cand_idx;
  logic [WIDTH-1:0] cand_data;
  logic [SEL_W-1:0] ptr_next;
  logic             cap;

  // Candidate channel: the direct index if in range, otherwise the first
  // enabled channel at or after the scan pointer, wrapping at CHANNELS.
  always_comb begin
    int idx;
    cand_found = 1'b0;
    cand_idx   = '0;
    idx        = 0;
    if (!bus.MODE) begin
      if (int'(bus.SEL) < CHANNELS) begin
        cand_found = 1'b1;
        cand_idx   = bus.SEL;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!cand_found && bus.EN[SEL_W'(idx)]) begin
          cand_found = 1'b1;
          cand_idx   = SEL_W'(idx);
        end
      end
    end
  end

  // Word of the candidate channel; a loop avoids indexing past D_IN when the
  // direct index is out of range.
  always_comb begin
    cand_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL_W'(k) == cand_idx) cand_data = bus.D_IN[k*WIDTH +: WIDTH];
    end
  end

  // Scan pointer successor, wrapping modulo CHANNELS rather than 2^SEL_W.
  always_comb begin
    ptr_next = (cand_idx == SEL_W'(CHANNELS - 1)) ? '0 : cand_idx + SEL_W'(1);
  end

  assign cap = (state_q == EMPTY) || bus.Z_READY;

  // Output register next state: load on a capture opportunity, hold on stall.
  // NOTE: every variable gets a default first so no path through this block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY, FULL: begin
        if (cap) begin
          if (cand_found) begin
            state_d = FULL;
            z_d     = cand_data;
            ch_d    = cand_idx;
            if (bus.MODE) ptr_d = ptr_next;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register with synchronous reset that overrides any capture.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      z_q     <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.Z       = z_q;
  assign bus.CH      = ch_q;
  assign bus.Z_VALID = (state_q == FULL);
endmodule

// File: tb/tb_mux_n_1_scan.sv
// Self-checking bench for mux_n_1_scan with three instances: 8 channels
// (power of two), 6 channels (out-of-range direct select) and 5 channels
// (non-power-of-two scan wrap). Expected words are pushed to a scoreboard
// when stimulus is driven and popped when the output register is sampled.
module tb_mux_n_1_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_n_1_scan_if #(.WIDTH(8), .CHANNELS(8)) b8 ();
  mux_n_1_scan_if #(.WIDTH(8), .CHANNELS(6)) b6 ();
  mux_n_1_scan_if #(.WIDTH(8), .CHANNELS(5)) b5 ();

  mux_n_1_scan #(.WIDTH(8), .CHANNELS(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  mux_n_1_scan #(.WIDTH(8), .CHANNELS(6)) u6 (.clk(clk), .rst(rst), .bus(b6));
  mux_n_1_scan #(.WIDTH(8), .CHANNELS(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

  typedef struct packed {
    logic [7:0] z;
    logic [2:0] ch;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic drive8(input logic [7:0] base);
    for (int k = 0; k < 8; k++) b8.D_IN[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic drive6(input logic [7:0] base);
    for (int k = 0; k < 6; k++) b6.D_IN[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic drive5(input logic [7:0] base);
    for (int k = 0; k < 5; k++) b5.D_IN[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b8.MODE = 1'b0; b8.SEL = 3'd5; b8.EN = 8'hFF; b8.Z_READY = 1'b0;
    drive8(8'hA0);
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (b8.Z_VALID !== 1'b0 || b8.Z !== 8'h00 || b8.CH !== 3'd0) begin
        n_errors++;
        $display("FAIL reset[%0d]: got valid=%b z=%h ch=%0d, expected valid=0 z=00 ch=0",
                 c, b8.Z_VALID, b8.Z, b8.CH);
      end
    end
    rst = 1'b0;
    sb_q.delete();
    sb_q.push_back('{z: 8'hA5, ch: 3'd5});
    step();
    e = sb_q.pop_front();
    n_checks++;
    if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
      n_errors++;
      $display("FAIL reset_release: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
               b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
    end
  endtask

  task automatic test_direct_sweep();
    do_reset();
    b8.MODE = 1'b0; b8.Z_READY = 1'b1;
    drive8(8'h10);
    for (int k = 0; k < 8; k++) begin
      b8.SEL = 3'(k);
      sb_q.push_back('{z: 8'h10 + 8'(k), ch: 3'(k)});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
        n_errors++;
        $display("FAIL direct_sweep[%0d]: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
                 k, b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
      end
    end
    // Six-channel instance: in-range select, then an index past the last channel.
    b6.MODE = 1'b0; b6.Z_READY = 1'b1; b6.SEL = 3'd2;
    drive6(8'h20);
    sb_q.push_back('{z: 8'h22, ch: 3'd2});
    step();
    e = sb_q.pop_front();
    n_checks++;
    if (b6.Z_VALID !== 1'b1 || b6.Z !== e.z || b6.CH !== e.ch) begin
      n_errors++;
      $display("FAIL direct_ch6_in_range: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
               b6.Z_VALID, b6.Z, b6.CH, e.z, e.ch);
    end
    b6.SEL = 3'd7;
    step();
    n_checks++;
    if (b6.Z_VALID !== 1'b0) begin
      n_errors++;
      $display("FAIL direct_ch6_out_of_range: got valid=%b, expected valid=0", b6.Z_VALID);
    end
    // Ready is irrelevant while empty: a capture happens even with ready low.
    b6.Z_READY = 1'b0; b6.SEL = 3'd3;
    sb_q.push_back('{z: 8'h23, ch: 3'd3});
    step();
    e = sb_q.pop_front();
    n_checks++;
    if (b6.Z_VALID !== 1'b1 || b6.Z !== e.z || b6.CH !== e.ch) begin
      n_errors++;
      $display("FAIL direct_empty_capture: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
               b6.Z_VALID, b6.Z, b6.CH, e.z, e.ch);
    end
  endtask

  task automatic test_scan_mask();
    int seq [3] = '{2, 5, 7};
    do_reset();
    b8.MODE = 1'b1; b8.EN = 8'b1010_0100; b8.Z_READY = 1'b1;
    drive8(8'h30);
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{z: 8'h30 + 8'(seq[i % 3]), ch: 3'(seq[i % 3])});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
        n_errors++;
        $display("FAIL scan_mask[%0d]: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
                 i, b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
      end
    end
    b8.EN = 8'h00;
    step();
    n_checks++;
    if (b8.Z_VALID !== 1'b0) begin
      n_errors++;
      $display("FAIL scan_no_enable: got valid=%b, expected valid=0", b8.Z_VALID);
    end
    b8.EN = 8'h01;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{z: 8'h30, ch: 3'd0});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
        n_errors++;
        $display("FAIL scan_single[%0d]: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
                 i, b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    b8.MODE = 1'b1; b8.EN = 8'hFF; b8.Z_READY = 1'b1;
    drive8(8'h40);
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back('{z: 8'h40 + 8'(k), ch: 3'(k)});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
        n_errors++;
        $display("FAIL stall_prime[%0d]: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
                 k, b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
      end
    end
    // Held word is channel 1 (0x41); inputs churn but nothing may move.
    b8.Z_READY = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive8(8'h50 + 8'(16 * c));
      b8.SEL = 3'(c);
      step();
      n_checks++;
      if (b8.Z_VALID !== 1'b1 || b8.Z !== 8'h41 || b8.CH !== 3'd1) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b z=%h ch=%0d, expected valid=1 z=41 ch=1",
                 c, b8.Z_VALID, b8.Z, b8.CH);
      end
    end
    b8.Z_READY = 1'b1;
    drive8(8'h90);
    sb_q.push_back('{z: 8'h92, ch: 3'd2});
    step();
    e = sb_q.pop_front();
    n_checks++;
    if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
      n_errors++;
      $display("FAIL stall_release: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
               b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
    end
  endtask

  task automatic test_wrap();
    // Scan 0..4,0,1 then direct 3,4 then scan resumes at pointer 2.
    int          chs  [11] = '{0, 1, 2, 3, 4, 0, 1, 3, 4, 2, 3};
    logic        mode [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    do_reset();
    b5.EN = 5'b11111; b5.Z_READY = 1'b1;
    drive5(8'h60);
    for (int i = 0; i < 11; i++) begin
      b5.MODE = mode[i];
      b5.SEL  = 3'(chs[i]);
      sb_q.push_back('{z: 8'h60 + 8'(chs[i]), ch: 3'(chs[i])});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (b5.Z_VALID !== 1'b1 || b5.Z !== e.z || b5.CH !== e.ch) begin
        n_errors++;
        $display("FAIL wrap[%0d]: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
                 i, b5.Z_VALID, b5.Z, b5.CH, e.z, e.ch);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seq [3] = '{3, 7, 3};
    do_reset();
    b8.MODE = 1'b1; b8.EN = 8'b1000_1000; b8.Z_READY = 1'b1;
    drive8(8'hC0);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{z: 8'hC0 + 8'(seq[i]), ch: 3'(seq[i])});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
        n_errors++;
        $display("FAIL reset_mid_prime[%0d]: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
                 i, b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
      end
    end
    // Pointer now 4; stall, then reset while full.
    b8.Z_READY = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (b8.Z_VALID !== 1'b0 || b8.Z !== 8'h00 || b8.CH !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_mid_clear: got valid=%b z=%h ch=%0d, expected valid=0 z=00 ch=0",
               b8.Z_VALID, b8.Z, b8.CH);
    end
    rst = 1'b0;
    sb_q.delete();
    sb_q.push_back('{z: 8'hC3, ch: 3'd3});
    step();
    e = sb_q.pop_front();
    n_checks++;
    if (b8.Z_VALID !== 1'b1 || b8.Z !== e.z || b8.CH !== e.ch) begin
      n_errors++;
      $display("FAIL reset_mid_restart: got valid=%b z=%h ch=%0d, expected valid=1 z=%h ch=%0d",
               b8.Z_VALID, b8.Z, b8.CH, e.z, e.ch);
    end
  endtask

  initial begin
    b8.MODE = 1'b0; b8.SEL = '0; b8.EN = '0; b8.D_IN = '0; b8.Z_READY = 1'b0;
    b6.MODE = 1'b0; b6.SEL = '0; b6.EN = '0; b6.D_IN = '0; b6.Z_READY = 1'b0;
    b5.MODE = 1'b0; b5.SEL = '0; b5.EN = '0; b5.D_IN = '0; b5.Z_READY = 1'b0;
    #2;
    test_reset();
    test_direct_sweep();
    test_scan_mask();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
